arm_register_file: RTL

//  Next-generation CPU register file: parametrised word width, register count and read-port count.

---
 rtl/arm_register_file.sv | 138 +++++++++++++
 1 files changed

// File: rtl/arm_register_file.sv
// arm_register_file: parametrised CPU register file with a dedicated program
// counter, link capture for branch-and-link, NZCV flags and write-to-read bypass.
//
// Ports
//   clock, reset       single clock, synchronous active-high reset
//   in_Read_address    NUM_READ packed read addresses (port k at [k*ADDR_WIDTH +: ADDR_WIDTH])
//   out_Read_data      NUM_READ packed combinational read data (port k at [k*WORD_WIDTH +: WORD_WIDTH])
//   in_Write_*         general writeback port
//   in_Pc_advance      PC <= PC + PC_STEP
//   in_Pc_load         PC <= in_Pc_data (branch target)
//   in_Link_enable     LR <= PC + PC_STEP (pre-update PC)
//   in_Flags_write     latch in_Flags ({N,Z,C,V})
//   out_Pc, out_Flags  registered PC (no read offset) and flags
module arm_register_file #(
    parameter int unsigned WORD_WIDTH     = 32,
    parameter int unsigned NUM_REGS       = 16,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned NUM_READ       = 3,
    parameter int unsigned PC_INDEX       = 15,
    parameter int unsigned LR_INDEX       = 14,
    parameter int unsigned PC_STEP        = 4,
    parameter int unsigned PC_READ_OFFSET = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]  in_Read_address,
    output logic [NUM_READ*WORD_WIDTH-1:0]  out_Read_data,
    input  logic                            in_Write_enable,
    input  logic [ADDR_WIDTH-1:0]           in_Write_address,
    input  logic [WORD_WIDTH-1:0]           in_Write_data,
    input  logic                            in_Pc_advance,
    input  logic                            in_Pc_load,
    input  logic [WORD_WIDTH-1:0]           in_Pc_data,
    input  logic                            in_Link_enable,
    input  logic                            in_Flags_write,
    input  logic [3:0]                      in_Flags,
    output logic [WORD_WIDTH-1:0]           out_Pc,
    output logic [3:0]                      out_Flags
);

    // Mask that clears the two low bits on every PC write (word alignment).
    localparam logic [WORD_WIDTH-1:0] PC_ALIGN_MASK = ~WORD_WIDTH'(3);

    logic [NUM_REGS-1:0][WORD_WIDTH-1:0] regs_q, regs_d;
    logic [WORD_WIDTH-1:0]               pc_q, pc_d;
    logic [3:0]                          flags_q, flags_d;

    logic [WORD_WIDTH-1:0] link_val_c;
    logic [WORD_WIDTH-1:0] pc_view_c;
    logic                  pc_write_c;
    logic                  lr_write_c;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [WORD_WIDTH-1:0] rd_word;

    assign link_val_c = pc_q + WORD_WIDTH'(PC_STEP);
    assign pc_view_c  = pc_q + WORD_WIDTH'(PC_READ_OFFSET);
    assign pc_write_c = in_Write_enable && (in_Write_address == ADDR_WIDTH'(PC_INDEX));
    assign lr_write_c = in_Write_enable && (in_Write_address == ADDR_WIDTH'(LR_INDEX));

    // General register next state: link first, then a general write overrides it.
    // The PC slot of the array is never written; the PC lives in pc_q.
    always_comb begin
        regs_d = regs_q;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (in_Link_enable && (i == LR_INDEX)) begin
                regs_d[i] = link_val_c;
            end
            if (in_Write_enable && (in_Write_address == ADDR_WIDTH'(i)) && (i != PC_INDEX)) begin
                regs_d[i] = in_Write_data;
            end
        end
    end

    // PC next state: general write > load > advance > hold; always word aligned.
    always_comb begin
        pc_d = pc_q;
        if (pc_write_c) begin
            pc_d = in_Write_data & PC_ALIGN_MASK;
        end else if (in_Pc_load) begin
            pc_d = in_Pc_data & PC_ALIGN_MASK;
        end else if (in_Pc_advance) begin
            pc_d = (pc_q + WORD_WIDTH'(PC_STEP)) & PC_ALIGN_MASK;
        end
    end

    // Flags next state.
    always_comb begin
        flags_d = flags_q;
        if (in_Flags_write) begin
            flags_d = in_Flags;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            regs_q  <= '0;
            pc_q    <= '0;
            flags_q <= '0;
        end else begin
            regs_q  <= regs_d;
            pc_q    <= pc_d;
            flags_q <= flags_d;
        end
    end

    // Read ports. PC reads use only the registered PC, so in_Pc_* never reach
    // out_Read_data. Out-of-range addresses read zero and are never bypassed.
    always_comb begin
        out_Read_data = '0;
        rd_addr       = '0;
        rd_word       = '0;
        for (int unsigned k = 0; k < NUM_READ; k++) begin
            rd_addr = in_Read_address[k*ADDR_WIDTH +: ADDR_WIDTH];
            rd_word = '0;
            if (rd_addr == ADDR_WIDTH'(PC_INDEX)) begin
                rd_word = pc_view_c;
            end else if (32'(rd_addr) < NUM_REGS) begin
                if (in_Write_enable && (in_Write_address == rd_addr)) begin
                    rd_word = in_Write_data;
                end else if (in_Link_enable && !lr_write_c && (rd_addr == ADDR_WIDTH'(LR_INDEX))) begin
                    rd_word = link_val_c;
                end else begin
                    for (int unsigned i = 0; i < NUM_REGS; i++) begin
                        if (rd_addr == ADDR_WIDTH'(i)) begin
                            rd_word = regs_q[i];
                        end
                    end
                end
            end
            out_Read_data[k*WORD_WIDTH +: WORD_WIDTH] = rd_word;
        end
    end

    assign out_Pc    = pc_q;
    assign out_Flags = flags_q;

endmodule
